// File: rtl/rom_cache_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rom_cache_if : CPU fetch port and ddram read port of the ROM cache
// Revision     : 1.0
// ---------------------------------------------------------------------------
interface rom_cache_if #(
  parameter int ADDR_W = 19
);
  logic              flush;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_req;
  logic              cpu_ack;
  logic [63:0]       cpu_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic              mem_ack;
  logic [63:0]       mem_data;

  // master: the core and ddram side; slave: the cache itself
  modport master (
    output flush, cpu_addr, cpu_req, mem_ack, mem_data,
    input  cpu_ack, cpu_data, mem_addr, mem_req
  );

  modport slave (
    input  flush, cpu_addr, cpu_req, mem_ack, mem_data,
    output cpu_ack, cpu_data, mem_addr, mem_req
  );
endinterface
`default_nettype wire

// File: rtl/rom_cache.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rom_cache : direct-mapped 64-bit ROM word cache with toggle handshakes
// Revision  : 1.0
// ---------------------------------------------------------------------------
module rom_cache #(
  parameter int LINES_LOG2 = 8,
  parameter int ADDR_W     = 19
) (
  input wire         clk_sys,
  input wire         reset,
  rom_cache_if.slave bus
);
  localparam int LINES = 1 << LINES_LOG2;
  localparam int TAG_W = ADDR_W - LINES_LOG2;

  typedef enum logic [2:0] {
    SWEEP  = 3'd0,
    IDLE   = 3'd1,
    LOOKUP = 3'd2,
    FILL   = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [LINES_LOG2-1:0] sweep_cnt_q, sweep_cnt_d;
  logic [ADDR_W-1:0]     req_addr_q, req_addr_d;
  logic                  cpu_ack_q, cpu_ack_d;
  logic [63:0]           cpu_data_q, cpu_data_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic                  mem_req_q, mem_req_d;
  logic                  flush_seen_q, flush_seen_d;

  logic [TAG_W:0]        tag_ram [LINES];
  logic [63:0]           data_ram [LINES];
  logic [TAG_W:0]        tag_rd_q;
  logic [63:0]           data_rd_q;

  logic                  tag_we;
  logic                  data_we;
  logic                  rd_en;
  logic [LINES_LOG2-1:0] wr_idx;
  logic [TAG_W:0]        tag_wdata;
  logic [LINES_LOG2-1:0] rd_idx;
  logic                  mem_done;
  logic                  hit;

  assign rd_idx   = bus.cpu_addr[LINES_LOG2-1:0];
  assign mem_done = (bus.mem_ack == mem_req_q);
  assign hit      = (tag_rd_q == {1'b1, req_addr_q[ADDR_W-1:LINES_LOG2]});

  assign bus.cpu_ack  = cpu_ack_q;
  assign bus.cpu_data = cpu_data_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_req  = mem_req_q;

  always_ff @(posedge clk_sys) begin
    if (tag_we) begin
      tag_ram[wr_idx] <= tag_wdata;
    end
    if (data_we) begin
      data_ram[wr_idx] <= bus.mem_data;
    end
    if (rd_en) begin
      tag_rd_q  <= tag_ram[rd_idx];
      data_rd_q <= data_ram[rd_idx];
    end
  end

  always_comb begin
    state_d      = state_q;
    sweep_cnt_d  = sweep_cnt_q;
    req_addr_d   = req_addr_q;
    cpu_ack_d    = cpu_ack_q;
    cpu_data_d   = cpu_data_q;
    mem_addr_d   = mem_addr_q;
    mem_req_d    = mem_req_q;
    flush_seen_d = flush_seen_q;
    tag_we       = 1'b0;
    data_we      = 1'b0;
    rd_en        = 1'b0;
    wr_idx       = sweep_cnt_q;
    tag_wdata    = '0;

    unique case (state_q)
      SWEEP: begin
        tag_we      = 1'b1;
        sweep_cnt_d = sweep_cnt_q + LINES_LOG2'(1);
        if (sweep_cnt_q == '1 && !bus.flush) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (bus.flush) begin
          state_d     = SWEEP;
          sweep_cnt_d = '0;
        end else if (bus.cpu_req != cpu_ack_q) begin
          req_addr_d = bus.cpu_addr;
          rd_en      = 1'b1;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        if (bus.flush) begin
          state_d     = SWEEP;
          sweep_cnt_d = '0;
        end else if (hit) begin
          cpu_data_d = data_rd_q;
          cpu_ack_d  = bus.cpu_req;
          state_d    = IDLE;
        end else begin
          mem_addr_d   = req_addr_q;
          mem_req_d    = ~mem_req_q;
          flush_seen_d = 1'b0;
          state_d      = FILL;
        end
      end
      FILL: begin
        flush_seen_d = flush_seen_q | bus.flush;
        if (mem_done) begin
          // A flush at any point during the fill makes the returned word stale.
          if (flush_seen_q || bus.flush) begin
            state_d     = SWEEP;
            sweep_cnt_d = '0;
          end else begin
            tag_we     = 1'b1;
            data_we    = 1'b1;
            wr_idx     = req_addr_q[LINES_LOG2-1:0];
            tag_wdata  = {1'b1, req_addr_q[ADDR_W-1:LINES_LOG2]};
            cpu_data_d = bus.mem_data;
            cpu_ack_d  = bus.cpu_req;
            state_d    = IDLE;
          end
        end
      end
      DRAIN: begin
        if (mem_done) begin
          state_d     = SWEEP;
          sweep_cnt_d = '0;
        end
      end
      default: begin
        state_d     = SWEEP;
        sweep_cnt_d = '0;
      end
    endcase

    if (reset) begin
      tag_we  = 1'b0;
      data_we = 1'b0;
    end
  end

  // mem_req_q relies on the register power-up value of 0 and is never reset,
  // so the toggle pair with ddram stays consistent across a reset.
  always_ff @(posedge clk_sys) begin
    mem_req_q  <= reset ? mem_req_q : mem_req_d;
    req_addr_q <= req_addr_d;
    if (reset) begin
      state_q      <= (mem_req_q != bus.mem_ack) ? DRAIN : SWEEP;
      sweep_cnt_q  <= '0;
      cpu_ack_q    <= 1'b0;
      cpu_data_q   <= '0;
      mem_addr_q   <= '0;
      flush_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_cnt_q  <= sweep_cnt_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_data_q   <= cpu_data_d;
      mem_addr_q   <= mem_addr_d;
      flush_seen_q <= flush_seen_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_rom_cache.sv
`default_nettype none
// tb_rom_cache : directed and soak checks of rom_cache against a toggle-handshake
// ddram model with programmable latency and a reference direct-mapped cache.
module tb_rom_cache;
  localparam int LINES_LOG2 = 8;
  localparam int ADDR_W     = 19;
  localparam int LINES      = 1 << LINES_LOG2;

  logic clk_sys = 1'b0;
  logic reset;

  rom_cache_if #(.ADDR_W(ADDR_W)) bus ();

  rom_cache #(.LINES_LOG2(LINES_LOG2), .ADDR_W(ADDR_W)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus.slave)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;

  int                mem_lat   = 10;
  int                mem_reqs  = 0;
  bit                resp_busy = 1'b0;
  int                resp_cnt  = 0;
  logic [ADDR_W-1:0] resp_addr = '0;
  logic [ADDR_W-1:0] last_mem_addr = '0;

  logic rst_mr_b, rst_mr_a, rst_ack_a;

  bit                ref_valid [LINES];
  logic [ADDR_W-1:0] ref_tag   [LINES];

  function automatic logic [63:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [63:0] d;
    d = 64'(a) - 64'h10;
    return 64'h0123456789ABCDEF ^ (d * 64'h9E3779B97F4A7C15);
  endfunction

  // ddram model: acks mem_lat cycles after seeing a new toggle
  always begin
    @(posedge clk_sys);
    #1;
    if (!resp_busy) begin
      if (bus.mem_req !== bus.mem_ack) begin
        resp_busy     = 1'b1;
        resp_cnt      = mem_lat;
        resp_addr     = bus.mem_addr;
        last_mem_addr = bus.mem_addr;
        mem_reqs++;
      end
    end else begin
      resp_cnt--;
      if (resp_cnt <= 0) begin
        bus.mem_data = mem_word(resp_addr);
        bus.mem_ack  = ~bus.mem_ack;
        resp_busy    = 1'b0;
      end
    end
  end

  task automatic do_req(input logic [ADDR_W-1:0] addr, input int flush_at, input int rst_at,
                        input bit scramble, input int budget,
                        output int lat, output logic [63:0] data, output int nreq);
    int cnt;
    int req0;
    req0         = mem_reqs;
    data         = '0;
    lat          = -1;
    cnt          = 0;
    bus.cpu_addr = addr;
    bus.cpu_req  = ~bus.cpu_req;
    while (lat < 0 && cnt < budget) begin
      @(posedge clk_sys);
      #1;
      cnt++;
      if (rst_at > 0 && cnt == rst_at + 1) begin
        reset     = 1'b0;
        rst_mr_a  = bus.mem_req;
        rst_ack_a = bus.cpu_ack;
      end
      if (rst_at > 0 && cnt == rst_at) begin
        rst_mr_b = bus.mem_req;
        reset    = 1'b1;
      end
      if (flush_at > 0 && cnt == flush_at)     bus.flush = 1'b1;
      if (flush_at > 0 && cnt == flush_at + 3) bus.flush = 1'b0;
      if (scramble && cnt == 1) bus.cpu_addr = ~addr;
      if (bus.cpu_ack == bus.cpu_req) begin
        lat  = cnt;
        data = bus.cpu_data;
      end
    end
    nreq = mem_reqs - req0;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.flush    = 1'b0;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = '0;
    bus.mem_ack  = 1'b0;
    bus.mem_data = '0;
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    total++; if (bus.cpu_ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", bus.cpu_ack); end
    total++; if (bus.cpu_data !== 64'd0) begin bad++; $display("FAIL reset_data: got %h want 0", bus.cpu_data); end
    total++; if (bus.mem_addr !== '0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
  endtask

  task automatic test_sweep_miss();
    int lat; int nreq; logic [63:0] d;
    mem_lat = 10;
    do_req(19'h00010, 0, 0, 1'b0, 400, lat, d, nreq);
    total++; if (lat !== 269) begin bad++; $display("FAIL sweep_miss_lat: got %0d want 269", lat); end
    total++; if (nreq !== 1) begin bad++; $display("FAIL sweep_miss_memreqs: got %0d want 1", nreq); end
    total++; if (last_mem_addr !== 19'h00010) begin bad++; $display("FAIL sweep_miss_mem_addr: got %h want 00010", last_mem_addr); end
    total++; if (d !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL sweep_miss_data: got %h want 0123456789abcdef", d); end
  endtask

  task automatic test_hit();
    int lat; int nreq; logic [63:0] d;
    do_req(19'h00010, 0, 0, 1'b1, 50, lat, d, nreq);
    total++; if (lat !== 2) begin bad++; $display("FAIL hit_lat: got %0d want 2", lat); end
    total++; if (nreq !== 0) begin bad++; $display("FAIL hit_memreqs: got %0d want 0", nreq); end
    total++; if (d !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL hit_data: got %h want 0123456789abcdef", d); end
  endtask

  task automatic test_conflict();
    int lat; int nreq; logic [63:0] d;
    mem_lat = 10;
    do_req(19'h00110, 0, 0, 1'b1, 50, lat, d, nreq);
    total++; if (lat !== 13 || nreq !== 1) begin bad++; $display("FAIL conflict_a_miss: got lat=%0d reqs=%0d want lat=13 reqs=1", lat, nreq); end
    total++; if (last_mem_addr !== 19'h00110) begin bad++; $display("FAIL conflict_a_addr: got %h want 00110", last_mem_addr); end
    total++; if (d !== mem_word(19'h00110)) begin bad++; $display("FAIL conflict_a_data: got %h want %h", d, mem_word(19'h00110)); end
    do_req(19'h00010, 0, 0, 1'b1, 50, lat, d, nreq);
    total++; if (lat !== 13 || nreq !== 1) begin bad++; $display("FAIL conflict_b_miss: got lat=%0d reqs=%0d want lat=13 reqs=1", lat, nreq); end
    total++; if (d !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL conflict_b_data: got %h want 0123456789abcdef", d); end
    do_req(19'h00010, 0, 0, 1'b1, 50, lat, d, nreq);
    total++; if (lat !== 2 || nreq !== 0) begin bad++; $display("FAIL conflict_b_rehit: got lat=%0d reqs=%0d want lat=2 reqs=0", lat, nreq); end
  endtask

  task automatic test_flush_fill();
    int lat; int nreq; logic [63:0] d;
    mem_lat = 10;
    // flush high for edges 5..7 while FILL waits; the fill is discarded and re-issued after the sweep
    do_req(19'h00020, 4, 0, 1'b0, 400, lat, d, nreq);
    total++; if (lat !== 282) begin bad++; $display("FAIL flush_fill_lat: got %0d want 282", lat); end
    total++; if (nreq !== 2) begin bad++; $display("FAIL flush_fill_memreqs: got %0d want 2", nreq); end
    total++; if (d !== mem_word(19'h00020)) begin bad++; $display("FAIL flush_fill_data: got %h want %h", d, mem_word(19'h00020)); end
    do_req(19'h00020, 0, 0, 1'b1, 50, lat, d, nreq);
    total++; if (lat !== 2 || nreq !== 0) begin bad++; $display("FAIL flush_refill_hit: got lat=%0d reqs=%0d want lat=2 reqs=0", lat, nreq); end
    do_req(19'h00110, 0, 0, 1'b1, 50, lat, d, nreq);
    total++; if (lat !== 13 || nreq !== 1) begin bad++; $display("FAIL flush_evicted_miss: got lat=%0d reqs=%0d want lat=13 reqs=1", lat, nreq); end
  endtask

  task automatic test_reset_fill();
    int lat; int nreq; logic [63:0] d;
    mem_lat = 8;
    if (bus.cpu_req == 1'b1) begin
      do_req(19'h00020, 0, 0, 1'b0, 50, lat, d, nreq);
    end
    // reset sampled at edge 4 while FILL is outstanding; ddram acks at edge 10
    do_req(19'h00030, 0, 3, 1'b0, 400, lat, d, nreq);
    total++; if (rst_mr_a !== rst_mr_b) begin bad++; $display("FAIL reset_fill_mem_req: got %b want %b", rst_mr_a, rst_mr_b); end
    total++; if (rst_ack_a !== 1'b0) begin bad++; $display("FAIL reset_fill_ack: got %b want 0", rst_ack_a); end
    total++; if (lat !== 278) begin bad++; $display("FAIL reset_fill_lat: got %0d want 278", lat); end
    total++; if (nreq !== 2) begin bad++; $display("FAIL reset_fill_memreqs: got %0d want 2", nreq); end
    total++; if (d !== mem_word(19'h00030)) begin bad++; $display("FAIL reset_fill_data: got %h want %h", d, mem_word(19'h00030)); end
  endtask

  task automatic test_soak();
    int lat; int nreq; logic [63:0] d;
    int exp_hits; int got_hits;
    logic [ADDR_W-1:0] a;
    int idx;
    bit exp_hit;
    @(posedge clk_sys);
    #1;
    bus.flush = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.flush = 1'b0;
    repeat (260) @(posedge clk_sys);
    #1;
    for (int i = 0; i < LINES; i++) begin
      ref_valid[i] = 1'b0;
      ref_tag[i]   = '0;
    end
    exp_hits = 0;
    got_hits = 0;
    for (int n = 0; n < 4096; n++) begin
      a       = ADDR_W'($urandom_range(0, 2047));
      mem_lat = $urandom_range(1, 20);
      idx     = int'(a[LINES_LOG2-1:0]);
      exp_hit = ref_valid[idx] && (ref_tag[idx] == (a >> LINES_LOG2));
      do_req(a, 0, 0, 1'b1, 100, lat, d, nreq);
      if (exp_hit) begin
        exp_hits++;
      end else begin
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = a >> LINES_LOG2;
      end
      if (nreq == 0) got_hits++;
      total++;
      if (d !== mem_word(a)) begin
        bad++; $display("FAIL soak_data: addr=%h got %h want %h", a, d, mem_word(a));
      end
      total++;
      if (exp_hit && (lat !== 2 || nreq !== 0)) begin
        bad++; $display("FAIL soak_hit: addr=%h got lat=%0d reqs=%0d want lat=2 reqs=0", a, lat, nreq);
      end else if (!exp_hit && (lat !== mem_lat + 3 || nreq !== 1)) begin
        bad++; $display("FAIL soak_miss: addr=%h got lat=%0d reqs=%0d want lat=%0d reqs=1", a, lat, nreq, mem_lat + 3);
      end
    end
    total++;
    if (got_hits !== exp_hits) begin
      bad++; $display("FAIL soak_hit_count: got %0d want %0d", got_hits, exp_hits);
    end
  endtask

  initial begin
    test_reset();
    test_sweep_miss();
    test_hit();
    test_conflict();
    test_flush_fill();
    test_reset_fill();
    test_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
